// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with a glitch-free, boundary-aligned ratio change (4-phase req/ack).
// Optional frequency monitor (meas_period/meas_valid) is built only when FREQ_MON_EN is defined.
module clk_div_ctrl #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             master_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_req,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ack,
    output logic             busy,
    output logic             div_clk,
    output logic             clk_en
`ifdef FREQ_MON_EN
    ,
    output logic [WIDTH-1:0] meas_period,
    output logic             meas_valid
`endif
);

    // state | meaning
    // IDLE  | stopped, div_clk low, counter parked at 0
    // RUN   | dividing with the active ratio
    // PEND  | dividing with the old ratio; new ratio loads at the period boundary
    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] ratio;
    logic [WIDTH-1:0] pend_div;

    logic             last;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] high_len;
    logic             accept;
    logic             go_idle;
    logic             rise;
    logic [WIDTH-1:0] div_clamped;

    always_comb begin
        last        = (cnt == ratio - ONE);
        cnt_nxt     = last ? '0 : cnt + ONE;
        high_len    = ratio - (ratio >> 1);
        accept      = cfg_req && !cfg_ack;
        go_idle     = (state != IDLE) && last && !en;
        rise        = (state == IDLE) ? en : (last && en);
        div_clamped = (cfg_div < TWO) ? TWO : cfg_div;
    end

    always_ff @(posedge master_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ratio    <= WIDTH'(DEFAULT_DIV);
            pend_div <= WIDTH'(DEFAULT_DIV);
            div_clk  <= 1'b0;
            clk_en   <= 1'b0;
            cfg_ack  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            clk_en <= rise;
            if (!cfg_req) begin
                cfg_ack <= 1'b0;
            end
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    div_clk <= en;
                    if (accept) begin
                        ratio   <= div_clamped;
                        cfg_ack <= 1'b1;
                    end
                    if (en) begin
                        state <= RUN;
                    end
                end
                RUN, PEND: begin
                    // A period is never cut short: stopping and ratio loads both wait for last
                    if (go_idle) begin
                        cnt     <= '0;
                        div_clk <= 1'b0;
                    end else begin
                        cnt     <= cnt_nxt;
                        div_clk <= (cnt_nxt < high_len);
                    end
                    if (state == RUN) begin
                        if (go_idle) begin
                            state <= IDLE;
                        end else if (accept) begin
                            pend_div <= div_clamped;
                            busy     <= 1'b1;
                            state    <= PEND;
                        end
                    end else if (last) begin
                        ratio   <= pend_div;
                        cfg_ack <= 1'b1;
                        busy    <= 1'b0;
                        state   <= en ? RUN : IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    div_clk <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef FREQ_MON_EN
    logic [WIDTH-1:0] mon_cnt;
    logic             mon_armed;

    // mon_cnt restarts at 1 on each rise so it equals the period length at the next rise
    always_ff @(posedge master_clk or posedge rst) begin
        if (rst) begin
            mon_cnt     <= '0;
            mon_armed   <= 1'b0;
            meas_period <= '0;
            meas_valid  <= 1'b0;
        end else if (go_idle) begin
            mon_armed  <= 1'b0;
            meas_valid <= 1'b0;
        end else if (rise) begin
            if (mon_armed) begin
                meas_period <= mon_cnt;
                meas_valid  <= 1'b1;
            end
            mon_armed <= 1'b1;
            mon_cnt   <= ONE;
        end else begin
            mon_cnt <= mon_cnt + ONE;
        end
    end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: vector table through a scoreboard queue, then reset-in-PEND and monitor sequences.
module tb_clk_div_ctrl;

    logic       master_clk = 1'b0;
    logic       rst;
    logic       en;
    logic       cfg_req;
    logic [7:0] cfg_div;
    logic       cfg_ack;
    logic       busy;
    logic       div_clk;
    logic       clk_en;
`ifdef FREQ_MON_EN
    logic [7:0] meas_period;
    logic       meas_valid;
`endif

    always #20 master_clk = ~master_clk;

    clk_div_ctrl #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
        .master_clk (master_clk),
        .rst        (rst),
        .en         (en),
        .cfg_req    (cfg_req),
        .cfg_div    (cfg_div),
        .cfg_ack    (cfg_ack),
        .busy       (busy),
        .div_clk    (div_clk),
        .clk_en     (clk_en)
`ifdef FREQ_MON_EN
        ,
        .meas_period(meas_period),
        .meas_valid (meas_valid)
`endif
    );

    // er = {en, cfg_req}; x = expected {div_clk, clk_en, cfg_ack, busy} after the edge
    typedef struct {
        logic [1:0] er;
        logic [7:0] d;
        logic [3:0] x;
    } vec_t;

    typedef struct {
        logic [3:0] x;
        string      tag;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic add(input logic [1:0] er, input logic [7:0] d, input logic [3:0] x);
        vec_t v;
        v.er = er;
        v.d  = d;
        v.x  = x;
        tbl.push_back(v);
    endtask

    task automatic step(input logic [1:0] er, input logic [7:0] d, input logic [3:0] x,
                        input string tag);
        exp_t e;
        @(negedge master_clk);
        en      = er[1];
        cfg_req = er[0];
        cfg_div = d;
        e.x     = x;
        e.tag   = tag;
        sb.push_back(e);
        @(posedge master_clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".div_clk"}, div_clk, e.x[3]);
            chk({e.tag, ".clk_en"},  clk_en,  e.x[2]);
            chk({e.tag, ".cfg_ack"}, cfg_ack, e.x[1]);
            chk({e.tag, ".busy"},    busy,    e.x[0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        cfg_req = 1'b0;
        cfg_div = 8'd0;
        #1;
        chk("reset.div_clk", div_clk, 1'b0);
        chk("reset.clk_en",  clk_en,  1'b0);
        chk("reset.cfg_ack", cfg_ack, 1'b0);
        chk("reset.busy",    busy,    1'b0);
`ifdef FREQ_MON_EN
        chk("reset.meas_valid",  meas_valid,  1'b0);
        chk("reset.meas_period", meas_period, 8'd0);
`endif
        repeat (2) @(negedge master_clk);
        rst = 1'b0;

        // default ratio 4: 2 high / 2 low, clk_en on each rise
        add(2'b10, 8'd0, 4'b1100); add(2'b10, 8'd0, 4'b1000);
        add(2'b10, 8'd0, 4'b0000); add(2'b10, 8'd0, 4'b0000);
        add(2'b10, 8'd0, 4'b1100); add(2'b10, 8'd0, 4'b1000);
        // request N=5 sampled at cnt=1: old period finishes, then 3 high / 2 low
        add(2'b11, 8'd5, 4'b0001); add(2'b11, 8'd5, 4'b0001);
        add(2'b11, 8'd5, 4'b1110); add(2'b11, 8'd5, 4'b1010);
        add(2'b10, 8'd5, 4'b1000); add(2'b10, 8'd0, 4'b0000);
        add(2'b10, 8'd0, 4'b0000); add(2'b10, 8'd0, 4'b1100);
        add(2'b10, 8'd0, 4'b1000); add(2'b10, 8'd0, 4'b1000);
        add(2'b10, 8'd0, 4'b0000); add(2'b10, 8'd0, 4'b0000);
        add(2'b00, 8'd0, 4'b0000); add(2'b00, 8'd0, 4'b0000);
        // cfg_div=1 in IDLE clamps to 2: 1 high / 1 low
        add(2'b01, 8'd1, 4'b0010); add(2'b11, 8'd1, 4'b1110);
        add(2'b10, 8'd1, 4'b0000); add(2'b10, 8'd0, 4'b1100);
        add(2'b10, 8'd0, 4'b0000); add(2'b10, 8'd0, 4'b1100);
        // N=6, en drops at cnt=1: full period completes, then IDLE
        add(2'b11, 8'd6, 4'b0001); add(2'b11, 8'd6, 4'b1110);
        add(2'b10, 8'd6, 4'b1000); add(2'b00, 8'd0, 4'b1000);
        add(2'b00, 8'd0, 4'b0000); add(2'b00, 8'd0, 4'b0000);
        add(2'b00, 8'd0, 4'b0000); add(2'b00, 8'd0, 4'b0000);
        add(2'b00, 8'd0, 4'b0000);

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].er, tbl[i].d, tbl[i].x, $sformatf("v%0d", i));

        // reset while PEND; request still high afterwards is taken as new
        step(2'b10, 8'd0, 4'b1100, "pend.run");
        step(2'b11, 8'd3, 4'b1001, "pend.enter");
        @(negedge master_clk);
        rst = 1'b1;
        en  = 1'b0;
        #1;
        chk("rstpend.div_clk", div_clk, 1'b0);
        chk("rstpend.busy",    busy,    1'b0);
        chk("rstpend.cfg_ack", cfg_ack, 1'b0);
        @(posedge master_clk);
        #1;
        chk("rstpend.hold_busy",   busy,   1'b0);
        chk("rstpend.hold_clk_en", clk_en, 1'b0);
        rst = 1'b0;
        step(2'b01, 8'd3, 4'b0010, "reacc.ack");
        step(2'b11, 8'd3, 4'b1110, "reacc.run");
        step(2'b10, 8'd3, 4'b1000, "reacc.c1");
        step(2'b10, 8'd3, 4'b0000, "reacc.c2");
        step(2'b10, 8'd3, 4'b1100, "reacc.rise");
`ifdef FREQ_MON_EN
        chk("mon3.valid",  meas_valid,  1'b1);
        chk("mon3.period", meas_period, 8'd3);
`endif
        step(2'b00, 8'd0, 4'b1000, "stop.c1");
        step(2'b00, 8'd0, 4'b0000, "stop.c2");
        step(2'b00, 8'd0, 4'b0000, "stop.idle");
`ifdef FREQ_MON_EN
        chk("monidle.valid", meas_valid, 1'b0);

        step(2'b01, 8'd5, 4'b0010, "mon.cfg5");
        step(2'b10, 8'd5, 4'b1100, "mon.run");
        chk("mon.first_rise_valid", meas_valid, 1'b0);
        for (int c = 1; c < 5; c++)
            step(2'b10, 8'd5, {(c < 3), 3'b000}, $sformatf("mon5.c%0d", c));
        step(2'b10, 8'd5, 4'b1100, "mon5.rise");
        chk("mon5.valid",  meas_valid,  1'b1);
        chk("mon5.period", meas_period, 8'd5);
        step(2'b11, 8'd7, 4'b1001, "mon7.pend");
        step(2'b11, 8'd7, 4'b1001, "mon7.p2");
        step(2'b11, 8'd7, 4'b0001, "mon7.p3");
        step(2'b11, 8'd7, 4'b0001, "mon7.p4");
        step(2'b11, 8'd7, 4'b1110, "mon7.load");
        chk("mon7.old_period", meas_period, 8'd5);
        for (int c = 1; c < 7; c++)
            step(2'b10, 8'd0, {(c < 4), 3'b000}, $sformatf("mon7.c%0d", c));
        step(2'b10, 8'd0, 4'b1100, "mon7.rise");
        chk("mon7.period", meas_period, 8'd7);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
